// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler: assembles 5-byte UART packets into motor commands,
// holds one pending command per channel and loads it when the motor is idle.

package motor_cmd_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   typedef struct packed {
      logic        dir;
      logic [14:0] steps;
      logic [14:0] divider;
   } mot_cmd_t;

endpackage

module motor_cmd_scheduler
   import motor_cmd_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH         = 10,
   parameter int unsigned TIMEOUT_CYCLES = 2400000,
   parameter int unsigned TMR_W          = 22
) (
   input  logic                  CLK_SE_AR,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   input  logic [NUM_CH-1:0]     motor_active,
   output logic [15*NUM_CH-1:0]  mot_divider,
   output logic [15*NUM_CH-1:0]  mot_steps,
   output logic [NUM_CH-1:0]     mot_dir,
   output logic [NUM_CH-1:0]     mot_load,
   output logic [NUM_CH-1:0]     pend_mask,
   output logic [NUM_CH-1:0]     busy_mask,
   output logic                  err_chan,
   output logic                  err_ovf,
   output logic                  err_tmo
);

   localparam int unsigned CNT_W     = 3;
   localparam int unsigned PKT_W     = 40;
   localparam logic [TMR_W-1:0] TMO_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   // parser state
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PKT_W-1:0]   shift_q, shift_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               err_tmo_q, err_tmo_d;

   // per-channel scheduling state
   mot_cmd_t [NUM_CH-1:0]     slot_q, slot_d;
   logic [NUM_CH-1:0]         pend_q, pend_d;
   logic [NUM_CH-1:0]         busy_q, busy_d;
   logic [NUM_CH-1:0]         seen_q, seen_d;
   logic [NUM_CH-1:0]         load_q, load_d;
   logic [NUM_CH-1:0][14:0]   div_q, div_d;
   logic [NUM_CH-1:0][14:0]   steps_q, steps_d;
   logic [NUM_CH-1:0]         dir_q, dir_d;
   logic                      err_chan_q, err_chan_d;
   logic                      err_ovf_q, err_ovf_d;

   logic [NUM_CH-1:0]         drain_c;
   logic [3:0]                cmd_ch_c;
   mot_cmd_t                  cmd_c;

   // a slot drains when occupied, the motor is idle and no load was just issued
   assign drain_c  = pend_q & ~busy_q & ~load_q;
   assign cmd_ch_c = shift_q[3:0];
   assign cmd_c    = '{dir: shift_q[34], steps: shift_q[33:19], divider: shift_q[18:4]};

   // byte parser: shifting, byte count, inter-byte timeout
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      tmr_d     = tmr_q;
      err_tmo_d = 1'b0;
      if (rx_valid) begin
         shift_d = {rx_data, shift_q[PKT_W-1:8]};
         tmr_d   = TMO_RELOAD;
         if (cnt_q == CNT_W'(4)) begin
            cnt_d   = '0;
            state_d = ST_COMMIT;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_RECV;
         end
      end else if (cnt_q != '0) begin
         if (tmr_q == '0) begin
            cnt_d     = '0;
            state_d   = ST_IDLE;
            err_tmo_d = 1'b1;
         end else begin
            tmr_d = tmr_q - TMR_W'(1);
         end
      end else begin
         state_d = ST_IDLE;
      end
   end

   // dispatch, busy tracking and commit of a completed packet into its slot
   always_comb begin
      slot_d     = slot_q;
      pend_d     = pend_q;
      busy_d     = busy_q;
      seen_d     = seen_q;
      load_d     = '0;
      div_d      = div_q;
      steps_d    = steps_q;
      dir_d      = dir_q;
      err_chan_d = 1'b0;
      err_ovf_d  = 1'b0;

      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (drain_c[c]) begin
            div_d[c]   = slot_q[c].divider;
            steps_d[c] = slot_q[c].steps;
            dir_d[c]   = slot_q[c].dir;
            load_d[c]  = 1'b1;
            pend_d[c]  = 1'b0;
            busy_d[c]  = |slot_q[c].steps;
            seen_d[c]  = 1'b0;
         end else if (busy_q[c]) begin
            if (seen_q[c] && !motor_active[c]) begin
               busy_d[c] = 1'b0;
               seen_d[c] = 1'b0;
            end else if (motor_active[c]) begin
               seen_d[c] = 1'b1;
            end
         end
      end

      if (state_q == ST_COMMIT) begin
         if (32'(cmd_ch_c) >= NUM_CH) begin
            err_chan_d = 1'b1;
         end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
               if (cmd_ch_c == 4'(c)) begin
                  // a slot drained this cycle is free, so the new write wins
                  if (pend_q[c] && !drain_c[c]) begin
                     err_ovf_d = 1'b1;
                  end else begin
                     slot_d[c] = cmd_c;
                     pend_d[c] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // state registers
   always_ff @(posedge CLK_SE_AR) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         tmr_q      <= '0;
         err_tmo_q  <= 1'b0;
         slot_q     <= '0;
         pend_q     <= '0;
         busy_q     <= '0;
         seen_q     <= '0;
         load_q     <= '0;
         div_q      <= '0;
         steps_q    <= '0;
         dir_q      <= '0;
         err_chan_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         tmr_q      <= tmr_d;
         err_tmo_q  <= err_tmo_d;
         slot_q     <= slot_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         seen_q     <= seen_d;
         load_q     <= load_d;
         div_q      <= div_d;
         steps_q    <= steps_d;
         dir_q      <= dir_d;
         err_chan_q <= err_chan_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   assign mot_divider = div_q;
   assign mot_steps   = steps_q;
   assign mot_dir     = dir_q;
   assign mot_load    = load_q;
   assign pend_mask   = pend_q;
   assign busy_mask   = busy_q;
   assign err_chan    = err_chan_q;
   assign err_ovf     = err_ovf_q;
   assign err_tmo     = err_tmo_q;

endmodule
